if2dec_queue: RTL and testbench
===============================

# if2dec_queue

Parametrised fetch-to-decode instruction queue: successor to the single-stage IF/DEC pipeline register. Holds up to DEPTH fetched instructions with valid/ready on both sides, drops fetch slots marked as jump-shadow, and flushes its whole contents on a redirect. It sits between the IFU fetch path and the decoder, decoupling I-cache response timing from decoder stalls.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- IW, 32, instruction width
- AW, 32, PC width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush_i  in  1  redirect/jump flush
- in_vld_i  in  1  fetch slot valid
- in_rdy_o  out  1  queue can accept a slot
- in_instr_i  in  IW  instruction
- in_pc_i  in  AW  instruction PC
- in_pc_j_i  in  1  slot is jump-shadow; consume but discard
- in_prdt_taken_i  in  1  branch predicted taken
- out_vld_o  out  1  head entry valid
- out_rdy_i  in  1  decoder accepts head
- out_instr_o  out  IW  head instruction
- out_pc_o  out  AW  head PC
- out_prdt_taken_o  out  1  head prediction bit
- count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular buffer of DEPTH entries {instr, pc, prdt_taken}; write pointer, read pointer, occupancy count.
- in_rdy_o = (count < DEPTH); it depends only on registered state and never on out_rdy_i.
- Handshake: in_fire = in_vld_i & in_rdy_o. The slot is written only when in_fire & ~in_pc_j_i & ~flush_i.
- Jump-shadow slots complete the handshake, but nothing is stored.
- out_vld_o = (count != 0). Outputs show the entry at the read pointer. pop = out_vld_o & out_rdy_i.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full: in_rdy_o = 0. A pop in the same cycle does not enable a push in that cycle.
- Empty: out_vld_o = 0. Out data holds its last value and must not be interpreted.
- flush_i has the highest priority:
  - On the next edge, count = 0 and both pointers = 0.
  - Any same-cycle push is discarded. A same-cycle pop is treated as consumed, with no effect on state.
- Pointers wrap modulo DEPTH.
- Entry data registers load only on a write, to save power.

## Timing
- Reset (rst low, asynchronous):
  - count and pointers clear to 0.
  - Every entry clears to 0, so out_vld_o = 0, out_instr_o = 0, out_pc_o = 0, out_prdt_taken_o = 0 and count_o = 0.
  - in_rdy_o = 1.
- Reset deasserted mid-operation: all contents are lost, and no slot is presented after reset.
- Latency without bypass: a slot pushed at edge N is visible on out_* in cycle N+1.
- Throughput: 1 slot per cycle in and out, sustained while 0 < count < DEPTH.
- flush_i asserted in cycle N: out_vld_o = 0 in cycle N+1. A push in cycle N+1 is accepted normally.

## Configuration
- IF2DEC_QUEUE_BYPASS_EN defined:
  - When count == 0 and in_vld_i & ~in_pc_j_i & ~flush_i, out_vld_o = 1 combinationally and out_* mirror the in_* fields in the same cycle.
  - If out_rdy_i is also 1, the slot is not written.
  - This gives zero latency when empty.
- Macro undefined: purely registered outputs, with 1-cycle minimum latency as above.
- In both cases, flush_i forces out_vld_o = 0 in the same cycle when the bypass is active.

## Structure
- IW and AW defaults come from `MYRISCV_INSTBUS` / `MYRISCV_ADDRBUS` widths in mydefines.v.
- Add an IF2DEC_QUEUE_DEPTH default constant there.
- Sub-module if2dec_queue_ptr handles pointer/count update:
  - Inputs: push, pop, flush.
  - Outputs: wptr, rptr, count, full, empty.
  - It uses the same clk/rst.
- Top level holds the storage array and output muxing.

## Test plan
- Reset, then 3 slots (pc 0x100/0x104/0x108), out_rdy_i = 0 → count_o = 3, out_pc_o = 0x100. Raise out_rdy_i → pops return 0x100, 0x104, 0x108 in order, then out_vld_o = 0.
- Fill with DEPTH = 4 → in_rdy_o = 0 at count 4. Pop and hold in_vld_i in the same cycle → no push, count 3. Next cycle push → count 4.
- Slot with in_pc_j_i = 1, pc 0x200, between 0x1FC and 0x204 → in handshake completes; output sequence 0x1FC, 0x204.
- Fill to 3, then flush_i with simultaneous push of 0x300 → next cycle count_o = 0, out_vld_o = 0, 0x300 absent. Push 0x400 → it is the next output.
- Continuous push/pop for 10 cycles → pointer wrap: outputs match inputs in order, and count stays at 1.
- With IF2DEC_QUEUE_BYPASS_EN, empty queue, push 0x500 with out_rdy_i = 1 → out_pc_o = 0x500 in the same cycle, and count_o stays 0.

Source files
------------

// File: rtl/if2dec_queue_pkg.sv
// Shared constants and types for the fetch-to-decode instruction queue.
// Build option: define IF2DEC_QUEUE_BYPASS_EN for a zero-latency path when the queue is empty.
package if2dec_queue_pkg;

  // Default widths follow the core-wide instruction and address bus widths.
  localparam int MYRISCV_INSTBUS_W  = 32;
  localparam int MYRISCV_ADDRBUS_W  = 32;
  localparam int IF2DEC_QUEUE_DEPTH = 4;

  // Pointer/count operation for one cycle, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } qop_e;

endpackage

// File: rtl/if2dec_queue_ptr.sv
// Read/write pointers and occupancy count of the fetch-to-decode queue.
// Flush has priority over push and pop. Pointers wrap modulo DEPTH, which must be a power of two.
module if2dec_queue_ptr
  import if2dec_queue_pkg::*;
#(
  parameter int DEPTH = IF2DEC_QUEUE_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH)-1:0]   wptr,
  output logic [$clog2(DEPTH)-1:0]   rptr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  qop_e op;

  assign op    = qop_e'({push, pop});
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Pointer and count update; a flush returns the queue to its post-reset state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          wptr  <= wptr + PW'(1);
          count <= count + CW'(1);
        end
        OP_POP: begin
          rptr  <= rptr + PW'(1);
          count <= count - CW'(1);
        end
        OP_BOTH: begin
          wptr <= wptr + PW'(1);
          rptr <= rptr + PW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/if2dec_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer between the IFU and the decoder.
// Jump-shadow slots complete the input handshake but are never stored; flush empties the queue.
// Build option: IF2DEC_QUEUE_BYPASS_EN presents an incoming slot combinationally when the queue is empty.
module if2dec_queue
  import if2dec_queue_pkg::*;
#(
  parameter int DEPTH = IF2DEC_QUEUE_DEPTH,
  parameter int IW    = MYRISCV_INSTBUS_W,
  parameter int AW    = MYRISCV_ADDRBUS_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     in_vld_i,
  output logic                     in_rdy_o,
  input  logic [IW-1:0]            in_instr_i,
  input  logic [AW-1:0]            in_pc_i,
  input  logic                     in_pc_j_i,
  input  logic                     in_prdt_taken_i,
  output logic                     out_vld_o,
  input  logic                     out_rdy_i,
  output logic [IW-1:0]            out_instr_o,
  output logic [AW-1:0]            out_pc_o,
  output logic                     out_prdt_taken_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          full;
  logic          empty;
  logic          in_fire;
  logic          wr_en;
  logic          rd_en;
  logic          byp;

  logic [IW-1:0] ent_instr_p0 [DEPTH];
  logic [AW-1:0] ent_pc_p0    [DEPTH];
  logic          ent_pt_p0    [DEPTH];

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign in_rdy_o = ~full;
  assign in_fire  = in_vld_i & in_rdy_o;

`ifdef IF2DEC_QUEUE_BYPASS_EN
  // An empty queue forwards a storable slot straight to the decoder; if it is taken now it is not stored.
  assign byp         = empty & in_vld_i & ~in_pc_j_i & ~flush_i;
  assign wr_en       = in_fire & ~in_pc_j_i & ~flush_i & ~(byp & out_rdy_i);
  assign out_vld_o   = ~empty | byp;
  assign out_instr_o = byp ? in_instr_i      : ent_instr_p0[rptr];
  assign out_pc_o    = byp ? in_pc_i         : ent_pc_p0[rptr];
  assign out_prdt_taken_o = byp ? in_prdt_taken_i : ent_pt_p0[rptr];
`else
  assign byp         = 1'b0;
  assign wr_en       = in_fire & ~in_pc_j_i & ~flush_i;
  assign out_vld_o   = ~empty;
  assign out_instr_o = ent_instr_p0[rptr];
  assign out_pc_o    = ent_pc_p0[rptr];
  assign out_prdt_taken_o = ent_pt_p0[rptr];
`endif

  // Only stored entries advance the read pointer; a bypassed slot never entered the buffer.
  assign rd_en = ~empty & out_rdy_i & ~flush_i & ~byp;

  if2dec_queue_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (rd_en),
    .flush (flush_i),
    .wptr  (wptr),
    .rptr  (rptr),
    .count (count_o),
    .full  (full),
    .empty (empty)
  );

  // ---- stage p0: entry storage, loaded only on an accepted, non-shadow, non-flushed slot ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_instr_p0[i] <= '0;
        ent_pc_p0[i]    <= '0;
        ent_pt_p0[i]    <= 1'b0;
      end
    end else if (wr_en) begin
      ent_instr_p0[wptr] <= in_instr_i;
      ent_pc_p0[wptr]    <= in_pc_i;
      ent_pt_p0[wptr]    <= in_prdt_taken_i;
    end
  end

endmodule

// File: tb/tb_if2dec_queue.sv
// Scoreboard bench for if2dec_queue: the driver queues each slot expected to reach the decoder,
// and a monitor pops and compares on every output handshake.
module tb_if2dec_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_vld_i = 1'b0;
  logic        in_rdy_o;
  logic [31:0] in_instr_i = '0;
  logic [31:0] in_pc_i = '0;
  logic        in_pc_j_i = 1'b0;
  logic        in_prdt_taken_i = 1'b0;
  logic        out_vld_o;
  logic        out_rdy_i = 1'b0;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;
  logic        out_prdt_taken_o;
  logic [2:0]  count_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pt;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  if2dec_queue #(.DEPTH(4), .IW(32), .AW(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .in_vld_i         (in_vld_i),
    .in_rdy_o         (in_rdy_o),
    .in_instr_i       (in_instr_i),
    .in_pc_i          (in_pc_i),
    .in_pc_j_i        (in_pc_j_i),
    .in_prdt_taken_i  (in_prdt_taken_i),
    .out_vld_o        (out_vld_o),
    .out_rdy_i        (out_rdy_i),
    .out_instr_o      (out_instr_o),
    .out_pc_o         (out_pc_o),
    .out_prdt_taken_o (out_prdt_taken_o),
    .count_o          (count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs; 'store' means this slot is expected to reach the decoder.
  task automatic drive(input logic vld, input logic [31:0] pc, input logic pj,
                       input logic rdy, input logic fl, input logic store);
    exp_t e;
    in_vld_i        = vld;
    in_pc_i         = pc;
    in_instr_i      = mk_instr(pc);
    in_pc_j_i       = pj;
    in_prdt_taken_i = pc[2];
    out_rdy_i       = rdy;
    flush_i         = fl;
    if (fl) expq.delete();
    if (store) begin
      e.pc = pc; e.instr = mk_instr(pc); e.pt = pc[2];
      expq.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic vld, input logic [31:0] pc, input logic pj,
                     input logic rdy, input logic fl, input logic store);
    drive(vld, pc, pj, rdy, fl, store);
    step();
  endtask

  // Monitor: every output handshake outside a flush must match the oldest expected slot.
  always @(negedge clk) begin
    if (rst && out_vld_o && out_rdy_i && !flush_i) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop: got pc %h required no output", out_pc_o);
      end else begin
        mon_e = expq.pop_front();
        chk("pop_pc", out_pc_o, mon_e.pc);
        chk("pop_instr", out_instr_o, mon_e.instr);
        chk("pop_pt", {31'd0, out_prdt_taken_o}, {31'd0, mon_e.pt});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_count", {29'd0, count_o}, 32'd0);
    chk("rst_out_vld", {31'd0, out_vld_o}, 32'd0);
    chk("rst_out_pc", out_pc_o, 32'd0);
    chk("rst_out_instr", out_instr_o, 32'd0);
    chk("rst_out_pt", {31'd0, out_prdt_taken_o}, 32'd0);
    chk("rst_in_rdy", {31'd0, in_rdy_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    // Three slots held, then drained in order
    cyc(1, 32'h100, 0, 0, 0, 1);
    cyc(1, 32'h104, 0, 0, 0, 1);
    cyc(1, 32'h108, 0, 0, 0, 1);
    chk("t1_count3", {29'd0, count_o}, 32'd3);
    chk("t1_head_pc", out_pc_o, 32'h100);
    repeat (3) cyc(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1_empty_vld", {31'd0, out_vld_o}, 32'd0);
    chk("t1_empty_count", {29'd0, count_o}, 32'd0);
    step();

    // Full: a same-cycle pop does not admit a push
    cyc(1, 32'h010, 0, 0, 0, 1);
    cyc(1, 32'h014, 0, 0, 0, 1);
    cyc(1, 32'h018, 0, 0, 0, 1);
    cyc(1, 32'h01C, 0, 0, 0, 1);
    chk("t2_count4", {29'd0, count_o}, 32'd4);
    chk("t2_full_rdy", {31'd0, in_rdy_o}, 32'd0);
    drive(1, 32'h020, 0, 1, 0, 0);
    @(negedge clk);
    chk("t2_rdy_during_pop", {31'd0, in_rdy_o}, 32'd0);
    step();
    chk("t2_count_after_pop", {29'd0, count_o}, 32'd3);
    cyc(1, 32'h020, 0, 0, 0, 1);
    chk("t2_count_refill", {29'd0, count_o}, 32'd4);
    repeat (4) cyc(0, 0, 0, 1, 0, 0);
    chk("t2_drained", {29'd0, count_o}, 32'd0);

    // Jump-shadow slot is consumed but not stored
    cyc(1, 32'h1FC, 0, 0, 0, 1);
    drive(1, 32'h200, 1, 0, 0, 0);
    @(negedge clk);
    chk("t3_shadow_rdy", {31'd0, in_rdy_o}, 32'd1);
    step();
    chk("t3_count_after_shadow", {29'd0, count_o}, 32'd1);
    cyc(1, 32'h204, 0, 0, 0, 1);
    chk("t3_count2", {29'd0, count_o}, 32'd2);
    repeat (2) cyc(0, 0, 0, 1, 0, 0);
    chk("t3_drained", {29'd0, count_o}, 32'd0);

    // Flush with a simultaneous push
    cyc(1, 32'h280, 0, 0, 0, 1);
    cyc(1, 32'h284, 0, 0, 0, 1);
    cyc(1, 32'h288, 0, 0, 0, 1);
    cyc(1, 32'h300, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("t4_flush_vld", {31'd0, out_vld_o}, 32'd0);
    chk("t4_flush_count", {29'd0, count_o}, 32'd0);
    step();
    cyc(1, 32'h400, 0, 0, 0, 1);
    chk("t4_count_after_push", {29'd0, count_o}, 32'd1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("t4_drained", {29'd0, count_o}, 32'd0);

    // Continuous push/pop across pointer wrap
    cyc(1, 32'h600, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 32'h604 + 32'(4 * i), 0, 1, 0, 1);
      chk("t5_count_steady", {29'd0, count_o}, 32'd1);
    end
    cyc(0, 0, 0, 1, 0, 0);
    chk("t5_drained", {29'd0, count_o}, 32'd0);

    // Empty queue with decoder ready: bypass vs. registered latency
    drive(1, 32'h500, 0, 1, 0, 1);
    @(negedge clk);
`ifdef IF2DEC_QUEUE_BYPASS_EN
    chk("t6_byp_vld", {31'd0, out_vld_o}, 32'd1);
    chk("t6_byp_pc", out_pc_o, 32'h500);
    step();
    chk("t6_byp_count", {29'd0, count_o}, 32'd0);
`else
    chk("t6_nobyp_vld", {31'd0, out_vld_o}, 32'd0);
    step();
    chk("t6_nobyp_count", {29'd0, count_o}, 32'd1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("t6_drained", {29'd0, count_o}, 32'd0);
`endif

    // Asynchronous reset mid-operation discards contents
    cyc(1, 32'h700, 0, 0, 0, 0);
    cyc(1, 32'h704, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("t7_rst_count", {29'd0, count_o}, 32'd0);
    chk("t7_rst_vld", {31'd0, out_vld_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("t7_after_rst_vld", {31'd0, out_vld_o}, 32'd0);
    step();

    chk("sb_leftover", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
